// File: rtl/gbus_rx_unit.sv
// Global-bus receive unit: filters bus beats for this core, buffers them and drains them into local memory.
// Optional `GBUS_RX_STATS_EN` adds write and stall statistics counters.
module gbus_rx_unit #(
    parameter int GBUS_DATA_WIDTH  = 64,
    parameter int GBUS_ADDR_WIDTH  = 16,
    parameter int LOCAL_ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH       = 4,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [GBUS_ADDR_WIDTH-1:0]                  gbus_addr,
    input  logic                                        gbus_wen,
    input  logic [GBUS_DATA_WIDTH-1:0]                  gbus_wdata,
    input  logic [GBUS_ADDR_WIDTH-LOCAL_ADDR_WIDTH-1:0] cfg_core_sel,
    input  logic [CNT_WIDTH-1:0]                        cfg_expect_cnt,
    input  logic                                        start,
    output logic                                        mem_wen,
    output logic [LOCAL_ADDR_WIDTH-1:0]                 mem_addr,
    output logic [GBUS_DATA_WIDTH-1:0]                  mem_wdata,
    input  logic                                        mem_ready,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        overflow_err,
`ifdef GBUS_RX_STATS_EN
    output logic [CNT_WIDTH-1:0]                        stat_beats,
    output logic [CNT_WIDTH-1:0]                        stat_stall,
`endif
    output logic [CNT_WIDTH-1:0]                        stray_cnt
);

    localparam int SEL_W   = GBUS_ADDR_WIDTH - LOCAL_ADDR_WIDTH;
    localparam int ENTRY_W = LOCAL_ADDR_WIDTH + GBUS_DATA_WIDTH;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    localparam logic [SEL_W-1:0]     SEL_BCAST = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [PTR_W:0]       PTR_ONE   = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]   exp_q, exp_d;
    logic [CNT_WIDTH-1:0]   push_cnt_q, push_cnt_d;
    logic [CNT_WIDTH-1:0]   pop_cnt_q, pop_cnt_d;
    logic [CNT_WIDTH-1:0]   stray_q, stray_d;
    logic                   overflow_q, overflow_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
`ifdef GBUS_RX_STATS_EN
    logic [CNT_WIDTH-1:0]   stat_beats_q, stat_beats_d;
    logic [CNT_WIDTH-1:0]   stat_stall_q, stat_stall_d;
`endif

    logic [ENTRY_W-1:0]     fifo_mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0]     fifo_head;
    logic [SEL_W-1:0]       beat_sel;
    logic                   beat_match;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   in_frame;
    logic                   do_push;
    logic                   do_pop;
    logic                   beat_lost;
    logic                   beat_stray;
    logic                   start_accept;

    assign beat_sel   = gbus_addr[GBUS_ADDR_WIDTH-1:LOCAL_ADDR_WIDTH];
    assign beat_match = gbus_wen && ((beat_sel == cfg_core_sel) || (beat_sel == SEL_BCAST));

    // Extra pointer MSB distinguishes full from empty when the index bits coincide.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr_q[PTR_W-1:0]];

    assign mem_wen   = !fifo_empty && (state_q == RECV);
    assign mem_addr  = fifo_empty ? '0 : fifo_head[ENTRY_W-1:GBUS_DATA_WIDTH];
    assign mem_wdata = fifo_empty ? '0 : fifo_head[GBUS_DATA_WIDTH-1:0];

    assign do_pop       = mem_wen && mem_ready;
    assign in_frame     = (state_q == RECV) && (push_cnt_q < exp_q);
    assign do_push      = beat_match && in_frame && (!fifo_full || do_pop);
    assign beat_lost    = beat_match && in_frame && fifo_full && !do_pop;
    assign beat_stray   = beat_match && !in_frame;
    assign start_accept = (state_q == IDLE) && start;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        exp_d      = exp_q;
        push_cnt_d = push_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        stray_d    = stray_q;
        overflow_d = overflow_q;

        if (do_push) begin
            wr_ptr_d   = wr_ptr_q + PTR_ONE;
            push_cnt_d = push_cnt_q + CNT_ONE;
        end
        if (do_pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            pop_cnt_d = pop_cnt_q + CNT_ONE;
        end
        if (beat_lost) begin
            overflow_d = 1'b1;
        end
        if (beat_stray && (stray_q != CNT_MAX)) begin
            stray_d = stray_q + CNT_ONE;
        end

        // Exit looks at the post-pop count so done follows the last write by one cycle.
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RECV;
                    exp_d      = cfg_expect_cnt;
                    push_cnt_d = '0;
                    pop_cnt_d  = '0;
                    overflow_d = 1'b0;
                end
            end
            RECV: begin
                if (pop_cnt_d == exp_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RECV);
        done_d = (state_d == DONE);
    end

`ifdef GBUS_RX_STATS_EN
    always_comb begin
        stat_beats_d = stat_beats_q;
        stat_stall_d = stat_stall_q;
        if (start_accept) begin
            stat_beats_d = '0;
            stat_stall_d = '0;
        end else begin
            if (do_pop && (stat_beats_q != CNT_MAX)) begin
                stat_beats_d = stat_beats_q + CNT_ONE;
            end
            if (mem_wen && !mem_ready && (stat_stall_q != CNT_MAX)) begin
                stat_stall_d = stat_stall_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_beats_q <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_beats_q <= stat_beats_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_beats = stat_beats_q;
    assign stat_stall = stat_stall_q;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            exp_q      <= '0;
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
            stray_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            exp_q      <= exp_d;
            push_cnt_q <= push_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            stray_q    <= stray_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Storage needs no reset: the empty flag masks stale entries from the outputs.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {gbus_addr[LOCAL_ADDR_WIDTH-1:0], gbus_wdata};
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign overflow_err = overflow_q;
    assign stray_cnt    = stray_q;

endmodule

// File: tb/tb_gbus_rx_unit.sv
// Self-checking bench for gbus_rx_unit: vector table for single-frame flows plus
// hand-written overflow, full-FIFO push/pop, stall and asynchronous reset sequences.
module tb_gbus_rx_unit;

   logic        clk;
   logic        rst_n;
   logic [15:0] gbus_addr;
   logic        gbus_wen;
   logic [63:0] gbus_wdata;
   logic [5:0]  cfg_core_sel;
   logic [15:0] cfg_expect_cnt;
   logic        start;
   logic        mem_wen;
   logic [9:0]  mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_ready;
   logic        busy;
   logic        done;
   logic        overflow_err;
   logic [15:0] stray_cnt;

   int errors = 0;
   int checks = 0;
   int writes = 0;

   typedef struct packed {
      logic [9:0]  addr;
      logic [63:0] data;
   } sb_t;

   sb_t sbQueue[$];
   sb_t sbEntry;

   typedef struct {
      logic        start;
      logic [15:0] cfgExp;
      logic        wen;
      logic [15:0] addr;
      logic        ready;
      logic        expectWrite;
      logic        eMemWen;
      logic        eBusy;
      logic        eDone;
      logic [15:0] eStray;
   } vec_t;

   vec_t vecs[$];

   gbus_rx_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .gbus_addr     (gbus_addr),
      .gbus_wen      (gbus_wen),
      .gbus_wdata    (gbus_wdata),
      .cfg_core_sel  (cfg_core_sel),
      .cfg_expect_cnt(cfg_expect_cnt),
      .start         (start),
      .mem_wen       (mem_wen),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_ready     (mem_ready),
      .busy          (busy),
      .done          (done),
      .overflow_err  (overflow_err),
      .stray_cnt     (stray_cnt)
   );

   // Free-running clock, rising edge active
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the bench can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [63:0] dataOf(input logic [15:0] a);
      return {32'hDA7A_5EED, 16'h0000, a};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic [15:0] exp, input logic wen,
                                input logic [15:0] addr, input logic ready);
      start          = st;
      cfg_expect_cnt = exp;
      gbus_wen       = wen;
      gbus_addr      = addr;
      gbus_wdata     = dataOf(addr);
      mem_ready      = ready;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic addVec(input logic st, input logic [15:0] exp, input logic wen,
                         input logic [15:0] addr, input logic ready, input logic sb,
                         input logic eWen, input logic eBusy, input logic eDone,
                         input logic [15:0] eStray);
      vec_t v;
      v.start = st; v.cfgExp = exp; v.wen = wen; v.addr = addr; v.ready = ready;
      v.expectWrite = sb; v.eMemWen = eWen; v.eBusy = eBusy; v.eDone = eDone; v.eStray = eStray;
      vecs.push_back(v);
   endtask

   task automatic expectBeat(input logic [15:0] addr);
      sbQueue.push_back({addr[9:0], dataOf(addr)});
   endtask

   task automatic resetDut();
      applyStimulus(1'b0, 16'd0, 1'b0, 16'h0000, 1'b0);
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      sbQueue.delete();
      tick();
   endtask

   // Scoreboard: every accepted memory write must match the oldest expected beat
   always @(negedge clk) begin
      if (rst_n && mem_wen && mem_ready) begin
         writes++;
         if (sbQueue.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb.unexpected_write: got write addr 0x%0h expected no write", mem_addr);
         end else begin
            sbEntry = sbQueue.pop_front();
            checkOutput("sb.mem_addr", 64'(mem_addr), 64'(sbEntry.addr));
            checkOutput("sb.mem_wdata", mem_wdata, sbEntry.data);
         end
      end
   end

   initial begin
      int writesBefore;
      bit doneSeen;

      rst_n        = 1'b0;
      cfg_core_sel = 6'd3;
      applyStimulus(1'b0, 16'd0, 1'b0, 16'h0000, 1'b1);
      #12;
      checkOutput("reset.mem_wen", 64'(mem_wen), 64'd0);
      checkOutput("reset.mem_addr", 64'(mem_addr), 64'd0);
      checkOutput("reset.mem_wdata", mem_wdata, 64'd0);
      checkOutput("reset.busy", 64'(busy), 64'd0);
      checkOutput("reset.done", 64'(done), 64'd0);
      checkOutput("reset.overflow_err", 64'(overflow_err), 64'd0);
      checkOutput("reset.stray_cnt", 64'(stray_cnt), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Four-beat frame, back-to-back, memory always ready
      addVec(1, 4, 0, 16'h0000, 1, 0, 0, 1, 0, 0);
      addVec(0, 4, 1, 16'h0C10, 1, 1, 1, 1, 0, 0);
      addVec(0, 4, 1, 16'h0C11, 1, 1, 1, 1, 0, 0);
      addVec(0, 4, 1, 16'h0C12, 1, 1, 1, 1, 0, 0);
      addVec(0, 4, 1, 16'h0C13, 1, 1, 1, 1, 0, 0);
      addVec(0, 4, 0, 16'h0000, 1, 0, 0, 0, 1, 0);
      addVec(0, 4, 0, 16'h0000, 1, 0, 0, 0, 0, 0);
      // Two-beat frame: foreign core ignored, broadcast and own beat accepted
      addVec(1, 2, 0, 16'h0000, 1, 0, 0, 1, 0, 0);
      addVec(0, 2, 1, 16'h1420, 1, 0, 0, 1, 0, 0);
      addVec(0, 2, 1, 16'hFC21, 1, 1, 1, 1, 0, 0);
      addVec(0, 2, 1, 16'h0C22, 1, 1, 1, 1, 0, 0);
      addVec(0, 2, 0, 16'h0000, 1, 0, 0, 0, 1, 0);
      addVec(0, 2, 0, 16'h0000, 1, 0, 0, 0, 0, 0);
      // Idle beats count as strays, then an empty frame
      addVec(0, 0, 1, 16'h0C50, 1, 0, 0, 0, 0, 1);
      addVec(0, 0, 1, 16'h0C51, 1, 0, 0, 0, 0, 2);
      addVec(0, 0, 1, 16'h0C52, 1, 0, 0, 0, 0, 3);
      addVec(1, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 3);
      addVec(0, 0, 0, 16'h0000, 1, 0, 0, 0, 1, 3);
      addVec(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 3);

      writesBefore = writes;
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].start, vecs[i].cfgExp, vecs[i].wen, vecs[i].addr, vecs[i].ready);
         if (vecs[i].expectWrite) expectBeat(vecs[i].addr);
         tick();
         checkOutput($sformatf("vec%0d.mem_wen", i), 64'(mem_wen), 64'(vecs[i].eMemWen));
         checkOutput($sformatf("vec%0d.busy", i), 64'(busy), 64'(vecs[i].eBusy));
         checkOutput($sformatf("vec%0d.done", i), 64'(done), 64'(vecs[i].eDone));
         checkOutput($sformatf("vec%0d.stray_cnt", i), 64'(stray_cnt), 64'(vecs[i].eStray));
      end
      applyStimulus(1'b0, 16'd0, 1'b0, 16'h0000, 1'b1);
      checkOutput("table.write_count", 64'(writes - writesBefore), 64'd6);
      checkOutput("table.sb_drained", 64'(sbQueue.size()), 64'd0);

      // Overflow: six beats into a four-deep FIFO with memory stalled
      resetDut();
      applyStimulus(1'b1, 16'd6, 1'b0, 16'h0000, 1'b0);
      tick();
      checkOutput("ovf.busy_after_start", 64'(busy), 64'd1);
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b0, 16'd6, 1'b1, 16'h0C30 + 16'(k), 1'b0);
         if (k < 4) expectBeat(16'h0C30 + 16'(k));
         tick();
         if (k == 3) checkOutput("ovf.full_no_error_yet", 64'(overflow_err), 64'd0);
      end
      applyStimulus(1'b0, 16'd6, 1'b0, 16'h0000, 1'b0);
      checkOutput("ovf.overflow_err", 64'(overflow_err), 64'd1);
      checkOutput("ovf.mem_wen_stalled", 64'(mem_wen), 64'd1);
      checkOutput("ovf.head_addr", 64'(mem_addr), 64'h030);
      checkOutput("ovf.lost_not_stray", 64'(stray_cnt), 64'd0);
      mem_ready    = 1'b1;
      writesBefore = writes;
      doneSeen     = 1'b0;
      for (int n = 0; n < 8; n++) begin
         tick();
         if (done) doneSeen = 1'b1;
      end
      checkOutput("ovf.write_count", 64'(writes - writesBefore), 64'd4);
      checkOutput("ovf.done_never", 64'(doneSeen), 64'd0);
      checkOutput("ovf.busy_stuck", 64'(busy), 64'd1);
      checkOutput("ovf.drained_mem_wen", 64'(mem_wen), 64'd0);
      checkOutput("ovf.sticky", 64'(overflow_err), 64'd1);

      // Full FIFO with a simultaneous pop accepts the push; head holds during a stall
      resetDut();
      applyStimulus(1'b1, 16'd6, 1'b0, 16'h0000, 1'b0);
      tick();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 16'd6, 1'b1, 16'h0C40 + 16'(k), 1'b0);
         expectBeat(16'h0C40 + 16'(k));
         tick();
      end
      checkOutput("full.head_addr", 64'(mem_addr), 64'h040);
      applyStimulus(1'b0, 16'd6, 1'b1, 16'h0C44, 1'b1);
      expectBeat(16'h0C44);
      tick();
      checkOutput("full.push_pop_no_ovf", 64'(overflow_err), 64'd0);
      checkOutput("full.head_advanced", 64'(mem_addr), 64'h041);
      applyStimulus(1'b0, 16'd6, 1'b0, 16'h0000, 1'b0);
      for (int n = 0; n < 3; n++) begin
         tick();
         checkOutput($sformatf("stall%0d.mem_wen", n), 64'(mem_wen), 64'd1);
         checkOutput($sformatf("stall%0d.mem_addr", n), 64'(mem_addr), 64'h041);
         checkOutput($sformatf("stall%0d.mem_wdata", n), mem_wdata, dataOf(16'h0C41));
      end
      applyStimulus(1'b0, 16'd6, 1'b1, 16'h0C45, 1'b1);
      expectBeat(16'h0C45);
      tick();
      applyStimulus(1'b0, 16'd6, 1'b0, 16'h0000, 1'b1);
      doneSeen = 1'b0;
      for (int n = 0; n < 20 && !doneSeen; n++) begin
         tick();
         if (done) doneSeen = 1'b1;
      end
      checkOutput("full.done_seen", 64'(doneSeen), 64'd1);
      checkOutput("full.no_ovf", 64'(overflow_err), 64'd0);
      checkOutput("full.sb_drained", 64'(sbQueue.size()), 64'd0);

      // Asynchronous reset mid-frame with two beats buffered
      applyStimulus(1'b0, 16'd0, 1'b1, 16'h0C5F, 1'b0);
      tick();
      applyStimulus(1'b1, 16'd4, 1'b0, 16'h0000, 1'b0);
      tick();
      applyStimulus(1'b0, 16'd4, 1'b1, 16'h0C60, 1'b0);
      tick();
      applyStimulus(1'b0, 16'd4, 1'b1, 16'h0C61, 1'b0);
      tick();
      applyStimulus(1'b0, 16'd4, 1'b0, 16'h0000, 1'b0);
      checkOutput("rst.pre_mem_wen", 64'(mem_wen), 64'd1);
      checkOutput("rst.pre_stray", 64'(stray_cnt), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst.async_mem_wen", 64'(mem_wen), 64'd0);
      checkOutput("rst.async_mem_addr", 64'(mem_addr), 64'd0);
      checkOutput("rst.async_mem_wdata", mem_wdata, 64'd0);
      checkOutput("rst.async_busy", 64'(busy), 64'd0);
      checkOutput("rst.async_done", 64'(done), 64'd0);
      checkOutput("rst.async_overflow", 64'(overflow_err), 64'd0);
      checkOutput("rst.async_stray", 64'(stray_cnt), 64'd0);
      tick();
      rst_n        = 1'b1;
      mem_ready    = 1'b1;
      writesBefore = writes;
      for (int n = 0; n < 5; n++) tick();
      checkOutput("rst.no_writes_after", 64'(writes - writesBefore), 64'd0);
      checkOutput("rst.idle_busy", 64'(busy), 64'd0);
      checkOutput("rst.idle_mem_wen", 64'(mem_wen), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
